// File: rtl/circuito_exp5_pkg.sv
// Shared definitions for the Genius-style game: state codes, sequence ROM and blank segments.
package circuito_exp5_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARA        = 4'h1,
    NOVA_SEQ       = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_SEQ    = 4'h7,
    FIM_ACERTO     = 4'hA,
    FIM_ERRO       = 4'hE
  } estado_t;

  // One-hot button code expected at each sequence position
  localparam logic [3:0] ROM_SEQ [16] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b0100, 4'b0010, 4'b0001, 4'b0001,
    4'b0010, 4'b0010, 4'b0100, 4'b0100,
    4'b1000, 4'b1000, 4'b0001, 4'b0100
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/circuito_exp5_jogo_if.sv
// Player/board signal bundle of the game block: the board drives jogar/botoes, the game drives the rest.
interface circuito_exp5_jogo_if;
  logic       jogar;
  logic [3:0] botoes;
  logic [3:0] leds;
  logic       pronto;
  logic       ganhou;
  logic       perdeu;
  logic       db_jogadaIgualMemoria;
  logic       db_enderecoIgualSequencia;
  logic       db_tem_jogada;
  logic       db_fimS;
  logic [6:0] display_sequencia;
  logic [6:0] display_jogada;
  logic [6:0] display_memoria;
  logic [6:0] display_endereco;
  logic [6:0] display_estado;

  modport master (
    output jogar, botoes,
    input  leds, pronto, ganhou, perdeu,
    input  db_jogadaIgualMemoria, db_enderecoIgualSequencia, db_tem_jogada, db_fimS,
    input  display_sequencia, display_jogada, display_memoria, display_endereco, display_estado
  );

  modport slave (
    input  jogar, botoes,
    output leds, pronto, ganhou, perdeu,
    output db_jogadaIgualMemoria, db_enderecoIgualSequencia, db_tem_jogada, db_fimS,
    output display_sequencia, display_jogada, display_memoria, display_endereco, display_estado
  );
endinterface

// File: rtl/circuito_exp5_jogo_hexa7seg.sv
// Hex digit to active-low seven-segment pattern, bit order gfedcba.
module hexa7seg (
  input  logic [3:0] hexa_i,
  output logic [6:0] seg_o
);

  // Pure lookup of the digit glyph
  always_comb begin
    seg_o = 7'b1111111;
    case (hexa_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/circuito_exp5_jogo.sv
// Genius-style memory game: FSM, counters, jogada register and sequence ROM.
// Define DEBUG_DISPLAYS_EN to drive the five hex debug displays; otherwise they stay blank.
module circuito_exp5_jogo
  import circuito_exp5_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [3:0] botoes,
  output logic [3:0] leds,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_jogadaIgualMemoria,
  output logic       db_enderecoIgualSequencia,
  output logic       db_tem_jogada,
  output logic       db_fimS,
  output logic [6:0] display_sequencia,
  output logic [6:0] display_jogada,
  output logic [6:0] display_memoria,
  output logic [6:0] display_endereco,
  output logic [6:0] display_estado
);

  estado_t    state_q;
  logic [3:0] endereco_q;
  logic [3:0] sequencia_q;
  logic [3:0] jogada_q;
  logic       prev_q;
  logic       pronto_q;
  logic       ganhou_q;
  logic       perdeu_q;

  logic [3:0] memoria_s;
  logic       igual_s;
  logic       fim_rodada_s;
  logic       fim_s;
  logic       tem_jogada_s;

  assign memoria_s    = ROM_SEQ[endereco_q];
  assign igual_s      = (jogada_q == memoria_s);
  assign fim_rodada_s = (endereco_q == sequencia_q);
  assign fim_s        = (sequencia_q == 4'hF);
  // Only a 0 -> nonzero transition of the buttons counts as a new press
  assign tem_jogada_s = (|botoes) & ~prev_q;

  // Previous-cycle "any button" level for the press detector
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= |botoes;
    end
  end

  // Game FSM with the datapath registers it controls and its registered verdict flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= INICIAL;
      endereco_q  <= 4'd0;
      sequencia_q <= 4'd0;
      jogada_q    <= 4'd0;
      pronto_q    <= 1'b0;
      ganhou_q    <= 1'b0;
      perdeu_q    <= 1'b0;
    end else begin
      case (state_q)
        INICIAL: begin
          if (jogar) state_q <= PREPARA;
        end
        PREPARA: begin
          sequencia_q <= 4'd0;
          endereco_q  <= 4'd0;
          jogada_q    <= 4'd0;
          state_q     <= NOVA_SEQ;
        end
        NOVA_SEQ: begin
          endereco_q <= 4'd0;
          state_q    <= ESPERA;
        end
        ESPERA: begin
          if (tem_jogada_s) state_q <= REGISTRA;
        end
        REGISTRA: begin
          jogada_q <= botoes;
          state_q  <= COMPARA;
        end
        COMPARA: begin
          if (!igual_s) begin
            state_q  <= FIM_ERRO;
            pronto_q <= 1'b1;
            perdeu_q <= 1'b1;
          end else if (!fim_rodada_s) begin
            state_q <= PROXIMA_JOGADA;
          end else if (!fim_s) begin
            state_q <= PROXIMA_SEQ;
          end else begin
            state_q  <= FIM_ACERTO;
            pronto_q <= 1'b1;
            ganhou_q <= 1'b1;
          end
        end
        PROXIMA_JOGADA: begin
          endereco_q <= endereco_q + 4'd1;
          state_q    <= ESPERA;
        end
        PROXIMA_SEQ: begin
          sequencia_q <= sequencia_q + 4'd1;
          state_q     <= NOVA_SEQ;
        end
        FIM_ACERTO, FIM_ERRO: begin
          if (jogar) begin
            state_q  <= PREPARA;
            pronto_q <= 1'b0;
            ganhou_q <= 1'b0;
            perdeu_q <= 1'b0;
          end
        end
        default: begin
          state_q <= INICIAL;
        end
      endcase
    end
  end

  assign leds                      = jogada_q;
  assign pronto                    = pronto_q;
  assign ganhou                    = ganhou_q;
  assign perdeu                    = perdeu_q;
  assign db_jogadaIgualMemoria     = igual_s;
  assign db_enderecoIgualSequencia = fim_rodada_s;
  assign db_tem_jogada             = tem_jogada_s;
  assign db_fimS                   = fim_s;

`ifdef DEBUG_DISPLAYS_EN
  hexa7seg u_hex_sequencia (.hexa_i(sequencia_q), .seg_o(display_sequencia));
  hexa7seg u_hex_jogada    (.hexa_i(jogada_q),    .seg_o(display_jogada));
  hexa7seg u_hex_memoria   (.hexa_i(memoria_s),   .seg_o(display_memoria));
  hexa7seg u_hex_endereco  (.hexa_i(endereco_q),  .seg_o(display_endereco));
  hexa7seg u_hex_estado    (.hexa_i(state_q),     .seg_o(display_estado));
`else
  assign display_sequencia = SEG_BLANK;
  assign display_jogada    = SEG_BLANK;
  assign display_memoria   = SEG_BLANK;
  assign display_endereco  = SEG_BLANK;
  assign display_estado    = SEG_BLANK;
`endif

endmodule

// File: tb/tb_circuito_exp5_jogo.sv
// Directed bench for circuito_exp5_jogo: reset, rounds, error, hold, win, mid-round reset.
module tb_circuito_exp5_jogo;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  circuito_exp5_jogo_if bus ();

  circuito_exp5_jogo dut (
    .clock                     (clock),
    .reset                     (reset),
    .jogar                     (bus.jogar),
    .botoes                    (bus.botoes),
    .leds                      (bus.leds),
    .pronto                    (bus.pronto),
    .ganhou                    (bus.ganhou),
    .perdeu                    (bus.perdeu),
    .db_jogadaIgualMemoria     (bus.db_jogadaIgualMemoria),
    .db_enderecoIgualSequencia (bus.db_enderecoIgualSequencia),
    .db_tem_jogada             (bus.db_tem_jogada),
    .db_fimS                   (bus.db_fimS),
    .display_sequencia         (bus.display_sequencia),
    .display_jogada            (bus.display_jogada),
    .display_memoria           (bus.display_memoria),
    .display_endereco          (bus.display_endereco),
    .display_estado            (bus.display_estado)
  );

  always #5 clock = ~clock;

`ifdef DEBUG_DISPLAYS_EN
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_E = 7'b0000110;
`else
  localparam logic [6:0] SEG_0 = 7'b1111111;
  localparam logic [6:0] SEG_A = 7'b1111111;
  localparam logic [6:0] SEG_E = 7'b1111111;
`endif

  localparam logic [3:0] SEQ [16] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b0100, 4'b0010, 4'b0001, 4'b0001,
    4'b0010, 4'b0010, 4'b0100, 4'b0100,
    4'b1000, 4'b1000, 4'b0001, 4'b0100
  };

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Hold a code for 10 cycles (counting detector pulses), then release for 10 cycles
  task automatic press(input logic [3:0] code);
    int pulses;
    pulses = 0;
    bus.botoes = code;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (bus.db_tem_jogada === 1'b1) pulses++;
      @(posedge clock);
      #1;
    end
    bus.botoes = 4'b0000;
    cycles(10);
    check("tem_pulses", 8'(pulses), 8'd1);
  endtask

  task automatic start_game();
    bus.jogar = 1'b1;
    cycles(5);
    bus.jogar = 1'b0;
    check("start_state", 8'(dut.state_q), 8'h3);
    check("start_seq", 8'(dut.sequencia_q), 8'h0);
    check("start_end", 8'(dut.endereco_q), 8'h0);
  endtask

  task automatic play_round(input int k);
    for (int j = 0; j <= k; j++) press(SEQ[j]);
  endtask

  initial begin
    bus.jogar  = 1'b0;
    bus.botoes = 4'b0000;
    cycles(3);
    reset = 1'b1;
    #1;
    check("rst_state", 8'(dut.state_q), 8'h0);
    check("rst_pronto", 8'(bus.pronto), 8'h0);
    check("rst_ganhou", 8'(bus.ganhou), 8'h0);
    check("rst_perdeu", 8'(bus.perdeu), 8'h0);
    check("rst_leds", 8'(bus.leds), 8'h0);
    check("rst_tem", 8'(bus.db_tem_jogada), 8'h0);
    check("rst_disp_estado", 8'(bus.display_estado), 8'(SEG_0));
    check("rst_end_eq_seq", 8'(bus.db_enderecoIgualSequencia), 8'h1);
    check("rst_jog_eq_mem", 8'(bus.db_jogadaIgualMemoria), 8'h0);
    check("rst_fimS", 8'(bus.db_fimS), 8'h0);
    cycles(10);
    check("idle_state", 8'(dut.state_q), 8'h0);

    // Rounds 1..3
    start_game();
    press(4'b0001);
    check("r1_seq", 8'(dut.sequencia_q), 8'h1);
    check("r1_end", 8'(dut.endereco_q), 8'h0);
    check("r1_state", 8'(dut.state_q), 8'h3);
    // First press of round 2 doubles as the long-hold check
    press(4'b0001);
    check("hold_end", 8'(dut.endereco_q), 8'h1);
    check("hold_leds", 8'(bus.leds), 8'h1);
    press(4'b0010);
    check("r2_seq", 8'(dut.sequencia_q), 8'h2);
    play_round(2);
    check("r3_seq", 8'(dut.sequencia_q), 8'h3);
    check("r3_end", 8'(dut.endereco_q), 8'h0);

    // Round 4 with a wrong multi-bit press
    press(4'b0001);
    check("r4_end", 8'(dut.endereco_q), 8'h1);
    press(4'b1010);
    check("err_perdeu", 8'(bus.perdeu), 8'h1);
    check("err_pronto", 8'(bus.pronto), 8'h1);
    check("err_ganhou", 8'(bus.ganhou), 8'h0);
    check("err_leds", 8'(bus.leds), 8'hA);
    check("err_state", 8'(dut.state_q), 8'hE);
    check("err_disp_estado", 8'(bus.display_estado), 8'(SEG_E));
    cycles(10);
    check("err_hold_state", 8'(dut.state_q), 8'hE);
    check("err_hold_perdeu", 8'(bus.perdeu), 8'h1);

    // Restart from FIM_ERRO, then reset in round 2 with endereco=1
    start_game();
    check("restart_perdeu", 8'(bus.perdeu), 8'h0);
    check("restart_leds", 8'(bus.leds), 8'h0);
    play_round(0);
    press(4'b0001);
    check("mid_end", 8'(dut.endereco_q), 8'h1);
    reset = 1'b0;
    #1;
    check("mid_rst_state", 8'(dut.state_q), 8'h0);
    check("mid_rst_end", 8'(dut.endereco_q), 8'h0);
    check("mid_rst_seq", 8'(dut.sequencia_q), 8'h0);
    check("mid_rst_leds", 8'(bus.leds), 8'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    cycles(2);
    check("post_rst_state", 8'(dut.state_q), 8'h0);

    // Full win
    start_game();
    for (int k = 0; k < 16; k++) begin
      play_round(k);
      if (k == 14) check("r15_fimS", 8'(bus.db_fimS), 8'h1);
    end
    check("win_ganhou", 8'(bus.ganhou), 8'h1);
    check("win_pronto", 8'(bus.pronto), 8'h1);
    check("win_perdeu", 8'(bus.perdeu), 8'h0);
    check("win_state", 8'(dut.state_q), 8'hA);
    check("win_fimS", 8'(bus.db_fimS), 8'h1);
    check("win_leds", 8'(bus.leds), 8'h4);
    check("win_disp_estado", 8'(bus.display_estado), 8'(SEG_A));
    start_game();
    check("replay_ganhou", 8'(bus.ganhou), 8'h0);
    check("replay_pronto", 8'(bus.pronto), 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
